// File: rtl/crc16_dec_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : crc16_dec_scheduler
// Brief   : Round-robin sharing of one CRC16 decoder among NUM_REQ requesters.
// Revision: 1.0
// ============================================================================
module crc16_dec_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int DEC_LATENCY = 4,
  parameter int SYNC_MIN    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    dec_sync,
  output logic [31:0]             dec_data,
  input  logic [31:0]             dec_code,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_code,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_RUN   = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [3:0]         r_cnt;
  logic [ID_W-1:0]    r_ptr;
  logic [31:0]        r_dec_data;
  logic [ID_W-1:0]    r_rsp_id;
  logic [31:0]        r_rsp_code;
  logic               r_rsp_valid;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_gidx;
  logic               w_found;
  logic [31:0]        w_sel;
  logic               w_accept;

  // Two passes give the wrap-around search order ptr+1 .. NUM_REQ-1, 0 .. ptr.
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid[i] && (i > int'(r_ptr))) begin
        w_found    = 1'b1;
        w_grant[i] = 1'b1;
        w_gidx     = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_found && req_valid[i] && (i <= int'(r_ptr))) begin
        w_found    = 1'b1;
        w_grant[i] = 1'b1;
        w_gidx     = ID_W'(i);
      end
    end
  end

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_sel = req_data[32*i +: 32];
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_found;

  always_comb begin
    w_next    = r_state;
    req_ready = '0;
    dec_sync  = 1'b1;
    busy      = 1'b1;
    case (r_state)
      S_CLEAR: begin
        if (r_cnt == 4'(SYNC_MIN - 1)) w_next = S_IDLE;
      end
      S_IDLE: begin
        busy      = 1'b0;
        req_ready = w_grant;
        if (w_accept) w_next = S_RUN;
      end
      S_RUN: begin
        dec_sync = 1'b0;
        if (r_cnt == 4'd0) w_next = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) w_next = S_CLEAR;
      end
      default: w_next = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_CLEAR;
      r_cnt       <= 4'd0;
      r_ptr       <= ID_W'(NUM_REQ - 1);
      r_dec_data  <= '0;
      r_rsp_id    <= '0;
      r_rsp_code  <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_CLEAR: r_cnt <= r_cnt + 4'd1;
        S_IDLE: begin
          if (w_accept) begin
            r_dec_data <= w_sel;
            r_rsp_id   <= w_gidx;
            r_ptr      <= w_gidx;
            r_cnt      <= 4'(DEC_LATENCY - 1);
          end
        end
        S_RUN: begin
          if (r_cnt == 4'd0) begin
            r_rsp_code  <= dec_code;
            r_rsp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cnt       <= 4'd0;
          end
        end
        default: r_cnt <= 4'd0;
      endcase
    end
  end

  assign dec_data  = r_dec_data;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_code  = r_rsp_code;

endmodule
`default_nettype wire

// File: tb/tb_crc16_dec_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_crc16_dec_scheduler
// Brief   : Directed bench with a timeline model of the scheduler and a stub decoder.
// Revision: 1.0
// ============================================================================
module tb_crc16_dec_scheduler;
  localparam int c_N = 4;
  localparam int c_L = 4;
  localparam int c_S = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [c_N-1:0]   req_valid;
  logic [32*c_N-1:0] req_data;
  logic [c_N-1:0]   req_ready;
  logic             dec_sync;
  logic [31:0]      dec_data;
  logic [31:0]      dec_code;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [31:0]      rsp_code;
  logic             busy;

  crc16_dec_scheduler #(.NUM_REQ(c_N), .ID_W(2), .DEC_LATENCY(c_L), .SYNC_MIN(c_S)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .dec_sync(dec_sync), .dec_data(dec_data),
    .dec_code(dec_code), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_code(rsp_code), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stub decoder: correct only once sync has been low for c_L cycles.
  int r_low = 0;
  always @(posedge clk) r_low <= dec_sync ? 0 : r_low + 1;
  assign dec_code = (!dec_sync && r_low >= c_L - 1) ? (dec_data ^ 32'h1) : 32'hDEADBEEF;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Timeline model: job accepted at cycle m_acc runs c_L cycles then responds.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          m_on = 0;
  int          m_ptr, m_acc, m_idle_from, m_rst_cycle, m_id;
  logic [31:0] m_data;

  int n_acc = 0, n_hs = 0, n_rise = 0, acc_cyc = 0, last_lat = 0;
  int low_run = 0, last_run = 0;
  bit prev_rv = 0;
  int q_id[$];
  logic [31:0] q_code[$];

  function automatic int rr_pick(input logic [c_N-1:0] v, input int p);
    for (int k = 1; k <= c_N; k++) begin
      int idx = (p + k) % c_N;
      if (((v >> idx) & 4'd1) != 0) return idx;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    int c, g;
    bit in_run, in_resp, in_idle;
    logic [c_N-1:0] exp_ready;
    c = cyc;
    in_run = 0; in_resp = 0; in_idle = 0; g = -1;
    if (m_on) begin
      if (m_acc >= 0) begin
        in_run  = (c <= m_acc + c_L);
        in_resp = !in_run;
      end else begin
        in_idle = (c >= m_idle_from);
      end
      g = in_idle ? rr_pick(req_valid, m_ptr) : -1;
      exp_ready = (g >= 0) ? c_N'(1 << g) : '0;
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("dec_sync", 32'(dec_sync), 32'(!in_run));
      chk("busy", 32'(busy), 32'(!in_idle));
      chk("rsp_valid", 32'(rsp_valid), 32'(in_resp));
      if (in_run || in_resp) chk("dec_data", dec_data, m_data);
      if (in_resp) begin
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_code", rsp_code, m_data ^ 32'h1);
      end
      if (c == m_rst_cycle) begin
        chk("rst_rsp_id", 32'(rsp_id), 32'h0);
        chk("rst_rsp_code", rsp_code, 32'h0);
        chk("rst_dec_data", dec_data, 32'h0);
      end
    end

    if ((req_valid & req_ready) != '0) begin
      n_acc++;
      acc_cyc = c;
    end
    if (rsp_valid && !prev_rv) begin
      n_rise++;
      last_lat = c - acc_cyc;
    end
    if (rsp_valid && rsp_ready) begin
      n_hs++;
      q_id.push_back(int'(rsp_id));
      q_code.push_back(rsp_code);
    end
    prev_rv = rsp_valid;
    if (!dec_sync) low_run++;
    else if (low_run > 0) begin
      last_run = low_run;
      low_run  = 0;
    end

    if (!reset) begin
      m_on        = 1;
      m_acc       = -1;
      m_ptr       = c_N - 1;
      m_idle_from = c + 1 + c_S;
      m_rst_cycle = c + 1;
    end else if (m_on) begin
      if (g >= 0) begin
        m_acc  = c;
        m_id   = g;
        m_ptr  = g;
        m_data = req_data[32*g +: 32];
      end else if (in_resp && rsp_ready) begin
        m_acc       = -1;
        m_idle_from = c + 1 + c_S;
      end
    end
  end

  function automatic int qid(input int i);
    return (i < q_id.size()) ? q_id[i] : -1;
  endfunction

  function automatic logic [31:0] qcode(input int i);
    return (i < q_code.size()) ? q_code[i] : 32'hXXXXXXXX;
  endfunction

  task automatic wait_acc(input int n);
    int t = 0;
    while (n_acc < n && t < 300) begin @(posedge clk); #1; t++; end
    if (n_acc < n) chk("timeout_acc", 32'(n_acc), 32'(n));
  endtask

  task automatic wait_hs(input int n);
    int t = 0;
    while (n_hs < n && t < 300) begin @(posedge clk); #1; t++; end
    if (n_hs < n) chk("timeout_hs", 32'(n_hs), 32'(n));
  endtask

  int rel_cyc;

  initial begin
    reset     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_data  = {32'h80000001, 32'hFFFE800D, 32'hA5A55A5A, 32'h00001234};
    repeat (3) @(posedge clk);
    #1;
    reset   = 1'b1;
    rel_cyc = cyc;

    // Reset release, wrap from ptr=3 and skip of idle requesters
    req_valid = 4'b1010;
    wait_acc(1);
    chk("ready_after_release", 32'(acc_cyc - rel_cyc), 32'd2);
    wait_acc(2);
    req_valid = '0;
    wait_hs(2);
    chk("wrap_first", 32'(qid(0)), 32'd1);
    chk("wrap_second", 32'(qid(1)), 32'd3);

    // Single job on requester 2
    req_valid = 4'b0100;
    wait_acc(3);
    req_valid = '0;
    wait_hs(3);
    chk("single_id", 32'(qid(2)), 32'd2);
    chk("single_code", qcode(2), 32'hFFFE800C);
    chk("single_latency", 32'(last_lat), 32'd5);
    chk("single_sync_low", 32'(last_run), 32'd4);

    // Back-pressure: response held 10 cycles with every requester pending
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    wait_acc(4);
    req_valid = 4'b1111;
    begin
      int t = 0;
      while (!rsp_valid && t < 50) begin @(posedge clk); #1; t++; end
    end
    repeat (10) @(posedge clk);
    #1;
    chk("bp_valid", 32'(rsp_valid), 32'd1);
    chk("bp_code", rsp_code, 32'h00001235);
    chk("bp_ready", 32'(req_ready), 32'd0);
    chk("bp_acc_count", 32'(n_acc), 32'd4);
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_hs(4);
    chk("bp_hs_code", qcode(3), 32'h00001235);

    // Fresh reset, then full round-robin with all requesters valid
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    req_valid = 4'b1111;
    wait_acc(9);
    req_valid = '0;
    wait_hs(9);
    chk("rr_0", 32'(qid(4)), 32'd0);
    chk("rr_1", 32'(qid(5)), 32'd1);
    chk("rr_2", 32'(qid(6)), 32'd2);
    chk("rr_3", 32'(qid(7)), 32'd3);
    chk("rr_4", 32'(qid(8)), 32'd0);

    // Reset during the second RUN cycle aborts the job
    req_valid = 4'b0010;
    wait_acc(10);
    req_valid = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_dec_sync", 32'(dec_sync), 32'd1);
    chk("abort_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("abort_no_rsp", 32'(n_rise), 32'd9);
    chk("abort_no_hs", 32'(n_hs), 32'd9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/crc16_dec_scheduler.md
Name: crc16_dec_scheduler

Overview:
Round-robin scheduler that shares one CRC16_decoder instance between NUM_REQ requesters.
- Grants one 32-bit codeword at a time.
- Drives the decoder's sync/Data inputs through the clear/run sequence.
- Waits a fixed decode latency, captures correct_code, and returns it with the requester ID over a valid/ready response channel.
- Sits between the link-side receive buffers and the single shared CRC16 decode datapath.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, requester ID width; must be at least clog2(NUM_REQ)
DEC_LATENCY, 4, cycles Data must be held with sync low before correct_code is valid (1..15)
SYNC_MIN, 2, minimum consecutive cycles sync is held high between jobs (1..15)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-low reset (reset==0 resets on the clk rising edge)
req_valid  input  NUM_REQ  per-requester codeword pending
req_data  input  32*NUM_REQ  codewords, requester i at bits [32*i+31:32*i]
req_ready  output  NUM_REQ  one-hot grant; accept = req_valid[i] & req_ready[i]
dec_sync  output  1  to decoder sync
dec_data  output  32  to decoder Data
dec_code  input  32  from decoder correct_code
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  ID_W  requester index of response
rsp_code  output  32  captured corrected codeword
busy  output  1  high in any state except IDLE

Behaviour:
- Reset (reset==0 at a clk edge), all registers:
  - state=CLEAR, dec_sync=1, dec_data=0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_code=0, busy=1.
  - clear counter=0, RR pointer=NUM_REQ-1, so requester 0 has first priority.
- Reset mid-operation aborts any job. The captured response is discarded and never presented.
- States:
  - CLEAR: dec_sync=1, req_ready=0. Counter increments each cycle. After SYNC_MIN cycles in CLEAR, go to IDLE.
  - IDLE: dec_sync=1, busy=0.
    - req_ready is combinational: one-hot on the first requester with req_valid=1, searching from ptr+1 with wrap-around. Zero if none.
    - On accept of requester i, on the same edge: dec_data<=req_data[i], rsp_id<=i, ptr<=i, run counter<=DEC_LATENCY-1, go to RUN.
  - RUN: dec_sync=0, dec_data held stable.
    - Counter decrements each cycle.
    - On the cycle counter==0: rsp_code<=dec_code, go to RESP. This is the DEC_LATENCY-th cycle with sync low.
  - RESP: dec_sync=1, dec_data held, rsp_valid=1, rsp_id/rsp_code stable.
    - On rsp_valid & rsp_ready: rsp_valid<=0, clear counter reset, go to CLEAR.
- Latency:
  - Accept edge at cycle T. RUN occupies cycles T+1..T+DEC_LATENCY.
  - rsp_valid rises at cycle T+DEC_LATENCY+1.
  - Next accept is no earlier than SYNC_MIN+1 cycles after the response handshake.
- Grant rules:
  - Only one job in flight.
  - req_ready is 0 outside IDLE.
  - Requesters dropping req_valid before grant lose nothing; grant is re-evaluated each IDLE cycle.
- Fairness: with all requesters continuously valid, grants cycle 0,1,2,3,0,... Wrap: after granting NUM_REQ-1, the search starts at 0.
- Back-pressure: rsp_ready low holds RESP indefinitely. dec_sync stays high and no new grant is issued.
- Simultaneous events:
  - Multiple valid requesters are resolved by the RR rule only.
  - A req_valid change in the accept cycle is ignored after the edge.
- Width rules:
  - No arithmetic on data.
  - Counters are 4 bits.
  - rsp_id is zero-extended index i.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release → dec_sync=1 and req_ready=0 for SYNC_MIN=2 cycles. req_ready appears on the 3rd cycle after release.
- Single job, default params: req_valid=4'b0100, req_data[95:64]=32'hFFFE800D. Stub decoder returns Data^32'h00000001 after 4 sync-low cycles.
  - req_ready=4'b0100 in IDLE.
  - dec_sync low for exactly 4 cycles with dec_data=32'hFFFE800D.
  - rsp_valid 5 cycles after accept, with rsp_id=2 and rsp_code=32'hFFFE800C.
- Round-robin: all four req_valid held high, rsp_ready=1 → rsp_id sequence 0,1,2,3,0 with no requester granted twice in a row.
- Wrap and skip: ptr=3, req_valid=4'b1010 → grant requester 1. Next grant is 3 (0 and 2 are idle).
- Back-pressure: rsp_ready=0 for 10 cycles in RESP.
  - rsp_valid, rsp_id and rsp_code stay stable; req_ready=0; dec_sync=1.
  - rsp_ready=1 → handshake, then CLEAR for 2 cycles.
- Reset mid-RUN: assert reset=0 on the 2nd RUN cycle → next cycle rsp_valid=0, dec_sync=1, busy=1. No response is ever emitted for the aborted job.
